// File: rtl/gate_sweep_checker.sv
// Clocked stimulus and capture stage for a 2-input gate. It sweeps {a,b} through
// 00..11, captures y at the end of each hold window, and compares the table with EXPECTED.
module gate_sweep_checker #(
  parameter int unsigned HOLD_CYCLES = 5,
  parameter logic [3:0]  EXPECTED    = 4'b0111
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] table_out,
  output logic [3:0] fail_mask
);

  localparam int unsigned CNT_W = $clog2(HOLD_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [1:0]       idx;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx_inc_c;
  logic [3:0]       table_next_c;

  // Table as it will look once the current vector's y is captured
  always_comb begin
    table_next_c      = table_out;
    table_next_c[idx] = y;
    idx_inc_c         = idx + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= 2'd0;
      cnt       <= '0;
      a         <= 1'b0;
      b         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      table_out <= 4'd0;
      fail_mask <= 4'd0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          a    <= 1'b0;
          b    <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            state     <= DRIVE;
            idx       <= 2'd0;
            cnt       <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            table_out <= 4'd0;
            fail_mask <= 4'd0;
          end
        end
        DRIVE: begin
          if (cnt == CNT_LAST) begin
            table_out <= table_next_c;
            if (idx == 2'd3) begin
              // Results register together with the final capture
              state     <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              a         <= 1'b0;
              b         <= 1'b0;
              pass      <= (table_next_c == EXPECTED);
              fail_mask <= table_next_c ^ EXPECTED;
            end else begin
              idx <= idx_inc_c;
              cnt <= '0;
              a   <= idx_inc_c[1];
              b   <= idx_inc_c[0];
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Directed bench for gate_sweep_checker: default hold with NAND, stuck-at-1 and AND gates,
// a restart pulse mid-sweep, reset mid-sweep, back-to-back sweeps, and HOLD_CYCLES = 1.
module tb_gate_sweep_checker;

  localparam int unsigned H = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, start1;
  logic [1:0] gate_sel;
  logic       y, y1;
  logic       a, b, busy, done, pass;
  logic [3:0] table_out, fail_mask;
  logic       a1, b1, busy1, done1, pass1;
  logic [3:0] table_out1, fail_mask1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // 0: NAND, 1: stuck at 1, 2: AND
  function automatic logic gate_model(input logic [1:0] sel, input logic ga, input logic gb);
    case (sel)
      2'd0:    return ~(ga & gb);
      2'd1:    return 1'b1;
      default: return ga & gb;
    endcase
  endfunction

  assign y  = gate_model(gate_sel, a, b);
  assign y1 = gate_model(gate_sel, a1, b1);

  gate_sweep_checker dut (
    .clk(clk), .rst(rst), .start(start), .y(y),
    .a(a), .b(b), .busy(busy), .done(done), .pass(pass),
    .table_out(table_out), .fail_mask(fail_mask)
  );

  gate_sweep_checker #(.HOLD_CYCLES(1), .EXPECTED(4'b0111)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .y(y1),
    .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
    .table_out(table_out1), .fail_mask(fail_mask1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full sweep on the default instance; optionally pulse start during vector 2
  task automatic sweep(input string name, input logic [3:0] exp_tab, input logic exp_pass,
                       input logic [3:0] exp_fm, input bit pulse_mid);
    start = 1'b1;
    step();
    start = 1'b0;
    check({name, " cleared"}, {done, pass, table_out, fail_mask}, 32'd0);
    for (int v = 0; v < 4; v++) begin
      for (int c = 0; c < int'(H); c++) begin
        check($sformatf("%s ab v%0d c%0d", name, v, c), {30'd0, a, b}, 32'(v));
        check($sformatf("%s busy/done v%0d c%0d", name, v, c), {30'd0, busy, done}, 32'd2);
        if (pulse_mid && v == 2 && c == 1) start = 1'b1;
        step();
        start = 1'b0;
      end
    end
    check({name, " done"}, {29'd0, done, busy, pass}, {29'd0, 1'b1, 1'b0, exp_pass});
    check({name, " ab idle"}, {30'd0, a, b}, 32'd0);
    check({name, " table"}, 32'(table_out), 32'(exp_tab));
    check({name, " fail_mask"}, 32'(fail_mask), 32'(exp_fm));
    step();
    check({name, " done sticky"}, {30'd0, done, busy}, 32'd2);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    start1   = 1'b0;
    gate_sel = 2'd0;
    repeat (3) step();
    rst = 1'b0;
    check("reset outputs", {busy, done, pass, a, b, table_out, fail_mask}, 32'd0);
    check("reset outputs h1", {busy1, done1, pass1, a1, b1, table_out1, fail_mask1}, 32'd0);
    repeat (2) step();
    check("idle holds", {busy, done, a, b}, 32'd0);

    sweep("nand", 4'b0111, 1'b1, 4'b0000, 1'b0);

    gate_sel = 2'd1;
    sweep("stuck1", 4'b1111, 1'b0, 4'b1000, 1'b0);

    gate_sel = 2'd2;
    sweep("and", 4'b1000, 1'b0, 4'b1111, 1'b0);

    gate_sel = 2'd0;
    sweep("restart_ignored", 4'b0111, 1'b1, 4'b0000, 1'b1);
    sweep("back_to_back", 4'b0111, 1'b1, 4'b0000, 1'b0);

    // Abort while vector 10 is on the gate
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (2 * H + 2) step();
    check("pre-abort ab", {30'd0, a, b}, 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort outputs", {busy, done, pass, a, b, table_out, fail_mask}, 32'd0);
    step();
    check("abort stays idle", {busy, done}, 32'd0);
    sweep("after_abort", 4'b0111, 1'b1, 4'b0000, 1'b0);

    // Single-cycle hold instance
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int v = 0; v < 4; v++) begin
      check($sformatf("h1 ab v%0d", v), {29'd0, busy1, a1, b1}, 32'(4 + v));
      check($sformatf("h1 done low v%0d", v), 32'(done1), 32'd0);
      step();
    end
    check("h1 done", {29'd0, done1, busy1, pass1}, 32'd5);
    check("h1 table", 32'(table_out1), 32'h7);
    check("h1 fail_mask", 32'(fail_mask1), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_sweep_checker.md
# gate_sweep_checker

Self-checking stimulus and capture stage for 2-input logic gates. It sits directly upstream and downstream of a gate under test, such as the NAND cell. It drives the four input combinations {a,b} = 00, 01, 10, 11 in order, holding each for a programmable number of cycles. It samples the gate output at the end of each hold window into a 4-bit truth table and compares that table with an expected pattern. It replaces hand-written delay stimulus with a clocked, reusable sweep that the gate benches and FPGA demos can instantiate.

## Interface
- HOLD_CYCLES, 5, cycles each input vector is held; legal range is ≥1.
- EXPECTED, 4'b0111, expected truth table. Bit i is the gate output for {a,b} = i. The default is NAND.

- clk  input  1  single clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  pulse that begins a sweep. Sampled only in IDLE or DONE.
- y  input  1  output of the gate under test (combinational from a, b).
- a  output  1  gate input a, registered.
- b  output  1  gate input b, registered.
- busy  output  1  high while a sweep is in progress.
- done  output  1  sticky completion flag.
- pass  output  1  high when table_out == EXPECTED. Valid while done = 1.
- table_out  output  4  captured truth table.
- fail_mask  output  4  table_out XOR EXPECTED. Valid while done = 1.

## Operation
- Reset values: a = 0, b = 0, busy = 0, done = 0, pass = 0, table_out = 0, fail_mask = 0. The state machine goes to IDLE.
- States:
  - IDLE: a and b are 0. start → DRIVE with idx = 0, hold counter = 0, table cleared.
  - DRIVE: {a,b} = idx; busy = 1.
    - The counter increments each cycle.
    - When counter == HOLD_CYCLES-1, y is captured into table_out[idx] on that edge.
    - If idx == 3, the next state is DONE. Otherwise idx increments and the counter clears.
  - DONE: done = 1, busy = 0, {a,b} = 00.
    - pass and fail_mask are registered on entry and hold until the next start or rst.
    - start → DRIVE, which clears done, pass, fail_mask and table_out.
- start while in DRIVE is ignored; the sweep is not restarted.
- Width of idx is 2 bits. The counter is $clog2(HOLD_CYCLES)+1 bits. HOLD_CYCLES = 1 captures on the first cycle of each vector.
- rst mid-sweep aborts immediately to the reset values. No partial table is retained.
- y must settle within one cycle of an a/b change. Capture happens only on the final hold cycle, so HOLD_CYCLES ≥ 2 tolerates glitches on the first cycle.

## Timing
- Let start be sampled high at edge k.
- busy = 1 and {a,b} = 00 from cycle k+1.
- Vector i is driven during cycles k+1+i·H through k+(i+1)·H, where H = HOLD_CYCLES.
- Capture of vector i occurs at edge k+(i+1)·H.
- done = 1, busy = 0 and pass/fail_mask are valid from cycle k+1+4H. The sweep latency is 4H+1 cycles from start to done.
- done stays high until the cycle after the next accepted start, or until rst.

## Test plan
- Default parameters with a real NAND model; start at edge 10 → a/b step 00, 01, 10, 11 every 5 cycles; done at cycle 31; table_out = 0111, pass = 1, fail_mask = 0000.
- y stuck at 1 → table_out = 1111, pass = 0, fail_mask = 1000. Swap in an AND gate → table_out = 1000, fail_mask = 1111.
- HOLD_CYCLES = 1 with NAND → each vector lasts 1 cycle; done 5 cycles after start; pass = 1.
- start pulsed again while busy (during vector 2) → sweep timing unchanged; done at the same cycle as without the extra pulse.
- rst asserted while vector 10 is driven → the next cycle shows all outputs 0 and busy = 0. A new start yields a clean table_out = 0111 with no residue.
- start from DONE → done, pass and table_out clear one cycle later; the second sweep completes with identical results.
